mem_wb_stage: RTL

- MEM/WB pipeline register and writeback-select stage of the 64-bit RISC-V core.
- Sits directly upstream of the register file and drives its WriteReg, WriteData and RegWrite inputs.
- Captures memory-stage results and performs load byte/half/word extraction with sign or zero extension.
- Selects the final writeback value, exports a forwarding tap for EX, and counts retired instructions.

---
 rtl/mem_wb_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback-select stage.
// Extracts load data, picks the writeback source and registers it for the
// register file. It also drives a forwarding tap for EX and counts retired
// instructions.
module mem_wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic             in_jump,
  input  logic [2:0]       in_funct3,
  input  logic [63:0]      in_alu_result,
  input  logic [63:0]      in_mem_rdata,
  input  logic [63:0]      in_pc_plus4,
  output logic [4:0]       WriteReg,
  output logic [63:0]      WriteData,
  output logic             RegWrite,
  output logic             wb_valid,
  output logic             fwd_en,
  output logic [4:0]       fwd_rd,
  output logic [63:0]      fwd_data,
  output logic [CNT_W-1:0] retired
);

  logic             wb_valid_q,  wb_valid_d;
  logic             reg_write_q, reg_write_d;
  logic [4:0]       rd_q,        rd_d;
  logic [63:0]      data_q,      data_d;
  logic [CNT_W-1:0] retired_q,   retired_d;

  logic [2:0]  off;
  logic [63:0] byte_sh, half_sh, word_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_word;
  logic [63:0] load_val;
  logic [63:0] sel;

  // Little-endian lane extraction and sign/zero extension for loads
  always_comb begin
    off      = in_alu_result[2:0];
    byte_sh  = in_mem_rdata >> {off, 3'b000};
    half_sh  = in_mem_rdata >> {off[2:1], 4'b0000};
    word_sh  = in_mem_rdata >> {off[2], 5'b00000};
    ld_byte  = byte_sh[7:0];
    ld_half  = half_sh[15:0];
    ld_word  = word_sh[31:0];
    load_val = in_mem_rdata;
    unique case (in_funct3)
      3'b000:  load_val = {{56{ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {56'd0, ld_byte};
      3'b001:  load_val = {{48{ld_half[15]}}, ld_half};
      3'b101:  load_val = {48'd0, ld_half};
      3'b010:  load_val = {{32{ld_word[31]}}, ld_word};
      3'b110:  load_val = {32'd0, ld_word};
      default: load_val = in_mem_rdata;
    endcase
  end

  // Writeback source select: link address, then load data, then ALU result
  always_comb begin
    sel = in_alu_result;
    if (in_jump) begin
      sel = in_pc_plus4;
    end else if (in_mem_to_reg) begin
      sel = load_val;
    end
  end

  // Next-state for the WB slot: flush beats stall, stall holds everything
  always_comb begin
    wb_valid_d  = wb_valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    data_d      = data_q;
    retired_d   = retired_q;
    if (flush) begin
      wb_valid_d  = 1'b0;
      reg_write_d = 1'b0;
      rd_d        = '0;
      data_d      = '0;
    end else if (!stall) begin
      wb_valid_d  = in_valid;
      reg_write_d = in_valid & in_reg_write & (in_rd != 5'd0);
      rd_d        = in_rd;
      data_d      = sel;
      if (in_valid) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  // Stage registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      retired_q   <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      retired_q   <= retired_d;
    end
  end

  assign WriteReg  = rd_q;
  assign WriteData = data_q;
  assign RegWrite  = reg_write_q;
  assign wb_valid  = wb_valid_q;
  assign retired   = retired_q;
  assign fwd_en    = reg_write_q;
  assign fwd_rd    = rd_q;
  assign fwd_data  = data_q;

endmodule
